// File: rtl/mem_taps.sv
// mem_taps: tapped delay line with per-tap valid flags.
// Tap 0 is the newest sample. listo pulses when a full set advances.
module mem_taps #(
   parameter int cant_bits = 25,
   parameter int taps      = 3,
   parameter int AUTO_DESP = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [cant_bits-1:0]      in,
   input  logic                      leer,
   input  logic                      desp,
   input  logic                      limpiar,
   output logic [taps*cant_bits-1:0] out_taps,
   output logic [taps-1:0]           validos,
   output logic [$clog2(taps+1)-1:0] cuenta,
   output logic                      lleno,
   output logic                      listo
);

   localparam int CW = $clog2(taps+1);

   logic [cant_bits-1:0] fss [taps];
   logic [taps-1:0]      v;
   logic [taps-1:0]      v_nx;
   logic                 sh;

   assign sh = (AUTO_DESP != 0) ? leer : desp;

   // Valid flags as they will look after this edge (ignoring flush)
   always_comb begin
      v_nx = v;
      if (sh)
         v_nx[taps-1:1] = v[taps-2:0];
      if (leer)
         v_nx[0] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < taps; k++)
            fss[k] <= '0;
         v     <= '0;
         listo <= 1'b0;
      end else if (limpiar) begin
         for (int k = 0; k < taps; k++)
            fss[k] <= '0;
         v     <= '0;
         listo <= 1'b0;
      end else begin
         if (leer)
            fss[0] <= in;
         if (sh)
            for (int k = 1; k < taps; k++)
               fss[k] <= fss[k-1];
         v     <= v_nx;
         listo <= sh && (&v_nx);
      end
   end

   for (genvar g = 0; g < taps; g++) begin : g_out
      assign out_taps[(g+1)*cant_bits-1 -: cant_bits] = fss[g];
   end

   assign validos = v;
   assign lleno   = &v;

   always_comb begin
      cuenta = '0;
      for (int k = 0; k < taps; k++)
         cuenta = cuenta + CW'(v[k]);
   end

endmodule

// File: tb/tb_mem_taps.sv
// tb_mem_taps: three mem_taps configurations against a queue-based model.
// Directed scenarios followed by a randomized run and a mid-run reset.
module tb_mem_taps;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        ld [3];
   logic        ds [3];
   logic        cl [3];
   logic [31:0] x  [3];

   logic [74:0] a_o, b_o;
   logic [39:0] c_o;
   logic [2:0]  a_v, b_v;
   logic [4:0]  c_v;
   logic [1:0]  a_c, b_c;
   logic [2:0]  c_c;
   logic        a_f, b_f, c_f;
   logic        a_l, b_l, c_l;

   mem_taps #(.cant_bits(25), .taps(3), .AUTO_DESP(0)) u_a (
      .clk(clk), .reset(rst), .in(x[0][24:0]), .leer(ld[0]),
      .desp(ds[0]), .limpiar(cl[0]), .out_taps(a_o), .validos(a_v),
      .cuenta(a_c), .lleno(a_f), .listo(a_l));

   mem_taps #(.cant_bits(25), .taps(3), .AUTO_DESP(1)) u_b (
      .clk(clk), .reset(rst), .in(x[1][24:0]), .leer(ld[1]),
      .desp(ds[1]), .limpiar(cl[1]), .out_taps(b_o), .validos(b_v),
      .cuenta(b_c), .lleno(b_f), .listo(b_l));

   mem_taps #(.cant_bits(8), .taps(5), .AUTO_DESP(0)) u_c (
      .clk(clk), .reset(rst), .in(x[2][7:0]), .leer(ld[2]),
      .desp(ds[2]), .limpiar(cl[2]), .out_taps(c_o), .validos(c_v),
      .cuenta(c_c), .lleno(c_f), .listo(c_l));

   int ncmp = 0;
   int nfail = 0;

   int          nt [3] = '{3, 3, 5};
   int          wd [3] = '{25, 25, 8};
   logic [31:0] md [3][5];
   bit          mv [3][5];
   bit          mlis [3];

   task automatic chk(string tag, logic [127:0] o, logic [127:0] e);
      ncmp++;
      assert (o === e) else begin
         nfail++;
         $error("FAIL %s got=%h exp=%h", tag, o, e);
      end
   endtask

   function automatic void mreset();
      for (int d = 0; d < 3; d++) begin
         for (int k = 0; k < 5; k++) begin
            md[d][k] = '0;
            mv[d][k] = 1'b0;
         end
         mlis[d] = 1'b0;
      end
   endfunction

   // Model: the taps are a fixed-length queue, newest at the front
   function automatic void mstep(int d, bit l, bit s, bit c, logic [31:0] xi);
      logic [31:0] q[$];
      bit          vq[$];
      bit          all;
      if (c) begin
         for (int k = 0; k < 5; k++) begin
            md[d][k] = '0;
            mv[d][k] = 1'b0;
         end
         mlis[d] = 1'b0;
         return;
      end
      for (int k = 0; k < nt[d]; k++) begin
         q.push_back(md[d][k]);
         vq.push_back(mv[d][k]);
      end
      if (s) begin
         q.push_front(q[0]);
         vq.push_front(vq[0]);
         void'(q.pop_back());
         void'(vq.pop_back());
      end
      if (l) begin
         q[0]  = xi & ((32'd1 << wd[d]) - 32'd1);
         vq[0] = 1'b1;
      end
      all = 1'b1;
      for (int k = 0; k < nt[d]; k++) begin
         md[d][k] = q[k];
         mv[d][k] = vq[k];
         all = all & vq[k];
      end
      mlis[d] = s && all;
   endfunction

   task automatic chkall(int d);
      logic [127:0] o, e;
      logic [7:0]   ov, oc, ev, ec;
      logic         of, ol, ef;
      case (d)
         0: begin o = 128'(a_o); ov = 8'(a_v); oc = 8'(a_c); of = a_f; ol = a_l; end
         1: begin o = 128'(b_o); ov = 8'(b_v); oc = 8'(b_c); of = b_f; ol = b_l; end
         default: begin o = 128'(c_o); ov = 8'(c_v); oc = 8'(c_c); of = c_f; ol = c_l; end
      endcase
      e = '0; ev = '0; ec = '0; ef = 1'b1;
      for (int k = 0; k < nt[d]; k++) begin
         e  = e | (128'(md[d][k]) << (k * wd[d]));
         ev = ev | (8'(mv[d][k]) << k);
         ec = ec + 8'(mv[d][k]);
         ef = ef & mv[d][k];
      end
      chk($sformatf("d%0d_taps", d), o, e);
      chk($sformatf("d%0d_validos", d), 128'(ov), 128'(ev));
      chk($sformatf("d%0d_cuenta", d), 128'(oc), 128'(ec));
      chk($sformatf("d%0d_lleno", d), 128'(of), 128'(ef));
      chk($sformatf("d%0d_listo", d), 128'(ol), 128'(mlis[d]));
   endtask

   task automatic idle_in();
      for (int d = 0; d < 3; d++) begin
         ld[d] = 1'b0; ds[d] = 1'b0; cl[d] = 1'b0; x[d] = '0;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      for (int d = 0; d < 3; d++)
         mstep(d, ld[d], (d == 1) ? ld[d] : ds[d], cl[d], x[d]);
      #1;
      for (int d = 0; d < 3; d++)
         chkall(d);
   endtask

   initial begin
      idle_in();
      mreset();
      #2;
      for (int d = 0; d < 3; d++)
         chkall(d);
      #5 rst = 1'b1;

      // leer+desp together on 5, 6, 7
      for (int i = 0; i < 3; i++) begin
         idle_in();
         ld[0] = 1'b1; ds[0] = 1'b1; x[0] = 32'(5 + i);
         cyc();
         chk("a_listo_seq", 128'(a_l), 128'(i == 2));
      end
      chk("a_567", 128'(a_o), {53'd0, 25'd5, 25'd6, 25'd7});
      chk("a_567_v", 128'(a_v), 128'(3'b111));
      chk("a_567_f", 128'(a_f), 128'(1));
      idle_in();
      cyc();
      chk("a_listo_drop", 128'(a_l), 128'(0));

      // flush beats load while full
      ld[0] = 1'b1; cl[0] = 1'b1; x[0] = 32'd99;
      cyc();
      chk("a_flush_taps", 128'(a_o), 128'(0));
      chk("a_flush_cnt", 128'(a_c), 128'(0));

      // load 9 then duplicate by shifting alone
      idle_in();
      ld[0] = 1'b1; x[0] = 32'd9;
      cyc();
      idle_in();
      ds[0] = 1'b1;
      cyc();
      cyc();
      chk("a_999", 128'(a_o), {53'd0, 25'd9, 25'd9, 25'd9});
      chk("a_999_v", 128'(a_v), 128'(3'b111));

      // auto shift: desp held high must not matter
      for (int i = 1; i <= 4; i++) begin
         idle_in();
         ds[1] = 1'b1; ld[1] = 1'b1; x[1] = 32'(i);
         cyc();
         chk("b_listo_pulse", 128'(b_l), 128'(i >= 3));
         idle_in();
         ds[1] = 1'b1;
         cyc();
         chk("b_listo_gap", 128'(b_l), 128'(0));
      end
      chk("b_234", 128'(b_o), {53'd0, 25'd2, 25'd3, 25'd4});

      // 8-bit x 5 taps, all ones, cuenta saturates
      for (int i = 1; i <= 7; i++) begin
         idle_in();
         ld[2] = 1'b1; ds[2] = 1'b1; x[2] = 32'h0000_00ff;
         cyc();
         chk("c_cuenta", 128'(c_c), 128'((i > 5) ? 5 : i));
      end
      chk("c_ff", 128'(c_o), 128'(40'hff_ffff_ffff));

      // randomized traffic with occasional flush
      for (int n = 0; n < 400; n++) begin
         for (int d = 0; d < 3; d++) begin
            ld[d] = 1'($urandom_range(0, 1));
            ds[d] = 1'($urandom_range(0, 1));
            cl[d] = ($urandom_range(0, 19) == 0);
            x[d]  = $urandom;
         end
         cyc();
      end

      // asynchronous reset with taps loaded
      idle_in();
      for (int i = 0; i < 5; i++) begin
         ld[0] = 1'b1; ld[1] = 1'b1; ld[2] = 1'b1;
         ds[0] = 1'b1; ds[2] = 1'b1;
         x[0] = $urandom; x[1] = $urandom; x[2] = $urandom;
         cyc();
      end
      #2 rst = 1'b0;
      #1;
      mreset();
      for (int d = 0; d < 3; d++)
         chkall(d);
      chk("a_rst_taps", 128'(a_o), 128'(0));
      chk("c_rst_lleno", 128'(c_f), 128'(0));
      #2 rst = 1'b1;
      idle_in();
      ld[0] = 1'b1; x[0] = 32'd3;
      cyc();
      chk("a_post_rst", 128'(a_o), 128'(3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule

// File: doc/mem_taps.md
MEM_TAPS -- requirements
Module: mem_taps

Interface
REQ-001 The module SHALL have parameter cant_bits, default 25, giving the sample width in bits (legal range 1 or more).
REQ-002 The module SHALL have parameter taps, default 3, giving the delay-line depth in taps (legal range 2 or more).
REQ-003 The module SHALL have parameter AUTO_DESP, default 0; 0 means separate load and shift strobes, 1 means leer alone both loads and shifts.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  reset, asynchronous and active-low; reset=0 SHALL clear all state immediately, independent of clk.
REQ-006 in  input  cant_bits  new sample.
REQ-007 leer  input  1  load strobe: capture in into tap 0.
REQ-008 desp  input  1  shift strobe; ignored when AUTO_DESP=1.
REQ-009 limpiar  input  1  synchronous flush of all taps and valid flags.
REQ-010 out_taps  output  taps*cant_bits  flattened tap contents; tap k SHALL occupy bits [(k+1)*cant_bits-1 : k*cant_bits]; tap 0 is the newest sample.
REQ-011 validos  output  taps  bit k SHALL be 1 when tap k holds a loaded sample.
REQ-012 cuenta  output  $clog2(taps+1)  number of set bits in validos.
REQ-013 lleno  output  1  SHALL be 1 exactly when every bit of validos is 1.
REQ-014 listo  output  1  one-cycle pulse; the full tap set has just advanced.

Function
REQ-015 Data registers fss[0..taps-1] and valid flags v[0..taps-1] SHALL all be clocked registers, with non-blocking semantics; every update SHALL use pre-edge values.
REQ-016 The effective shift SHALL be: sh = desp when AUTO_DESP=0, and sh = leer when AUTO_DESP=1.
REQ-017 On leer=1: fss[0] <= in and v[0] <= 1; otherwise fss[0] and v[0] SHALL hold.
REQ-018 On sh=1, for k = 1..taps-1: fss[k] <= old fss[k-1] and v[k] <= old v[k-1]; otherwise these registers SHALL hold.
REQ-019 leer and desp both 1 (AUTO_DESP=0): tap 1 SHALL receive the pre-edge tap 0 value, and tap 0 SHALL receive in; no sample is lost or duplicated.
REQ-020 desp=1 with leer=0 SHALL leave tap 0 and v[0] unchanged, so tap 0 is duplicated into tap 1.
REQ-021 The oldest tap value SHALL be discarded on each shift; there SHALL be no overflow flag and no wrap-around.
REQ-022 limpiar=1 SHALL take priority over leer and desp: on that edge all fss <= 0, all v <= 0, and listo <= 0.
REQ-023 out_taps, validos, cuenta and lleno SHALL be combinational functions of the registers only, with no extra latency: the value is visible in the cycle after the edge.
REQ-024 listo SHALL be registered: 1 in the cycle after an edge where sh=1, limpiar=0 and the post-edge v is all ones; otherwise 0.
REQ-025 With AUTO_DESP=1, listo SHALL first assert after the taps-th leer pulse counted from empty.
REQ-026 cuenta SHALL never exceed taps and SHALL be non-decreasing, except on limpiar or reset.

Reset
REQ-027 While reset=0, every fss, every v, listo, out_taps, validos, cuenta and lleno SHALL be 0, asynchronously.
REQ-028 Reset deassertion SHALL take effect on the next rising clk edge with no further initialisation; an operation in flight at reset assertion SHALL be abandoned without partial state.
REQ-029 The design SHALL NOT rely on initial blocks for reset values.

Verification (cant_bits=25, taps=3 unless stated)
REQ-030 The bench SHALL cover: reset low mid-simulation with taps loaded -> all outputs 0 within the same cycle, without a clk edge.
REQ-031 The bench SHALL cover: AUTO_DESP=0, with leer+desp together on samples 5, 6, 7 on consecutive edges -> out_taps = {5,6,7} (tap2..tap0), validos=3'b111, lleno=1, listo=1 one cycle after the third edge only.
REQ-032 The bench SHALL cover: AUTO_DESP=0, leer=1 with in=9 then desp alone for 2 edges -> taps {9,9,9}, validos=3'b111.
REQ-033 The bench SHALL cover: AUTO_DESP=1, leer pulses with 1, 2, 3, 4 and desp held at 1 throughout -> after 4 pulses taps {2,3,4}, listo pulses after pulses 3 and 4, and the desp input has no effect.
REQ-034 The bench SHALL cover: limpiar=1 and leer=1 on the same edge with taps full -> all taps 0, cuenta=0, lleno=0, listo=0.
REQ-035 The bench SHALL cover: cant_bits=8 and taps=5 with in=0xFF -> no truncation or sign-extension in any tap, the flattened bit positions follow REQ-010, and cuenta steps 1..5 and then saturates.
